// File: rtl/aes_decipher_sched_pkg.sv
// Shared AES scheduler types: FSM state encoding, key-length codes, round counts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_decipher_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_RESP   = 2'd3
  } sched_state_t;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  localparam int unsigned AES128_ROUNDS = 10;
  localparam int unsigned AES256_ROUNDS = 14;

  localparam int unsigned WDOG_W = 8;

  // One captured job: ciphertext, key length and originating requester.
  typedef struct packed {
    logic [127:0] block;
    logic         keylen;
    logic         id;
  } job_t;

  // Round count the engine runs for a given key length.
  function automatic int unsigned aes_num_rounds(input logic keylen);
    return (keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
  endfunction

endpackage

// File: rtl/aes_decipher_sched_arb.sv
// aes_rr_arb2: two-way round-robin arbiter with a last-grant register.
// Latency: grant is combinational from the requests; last-grant updates on the clock.
// Backpressure: last-grant only advances when the caller actually takes the grant.
module aes_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic gnt0,
  output logic gnt1,
  output logic gnt_id,
  output logic gnt_any
);

  // Reset to 1 so that requester 0 wins the first contention.
  logic last_gnt;

  // Pick the requester not granted last when both ask; otherwise the lone asker.
  always_comb begin
    gnt_id = 1'b0;
    if (req0 && req1) begin
      gnt_id = ~last_gnt;
    end else if (req1) begin
      gnt_id = 1'b1;
    end
  end

  assign gnt_any = req0 | req1;
  assign gnt0    = gnt_any & ~gnt_id;
  assign gnt1    = gnt_any &  gnt_id;

  // Remember who was served so the other side gets the next contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (advance && gnt_any) begin
      last_gnt <= gnt_id;
    end
  end

endmodule

// File: rtl/aes_decipher_sched.sv
// aes_decipher_sched: shares one AES decipher engine between two requesters.
// Latency: accept cycle, one launch cycle, engine time, then rsp_valid on the following cycle.
// Backpressure: one job in flight; req*_ready low until the rsp handshake, result held while rsp_ready=0.
// Option: define AES_SCHED_TIMEOUT_EN for the BUSY watchdog and the rsp_err output.
module aes_decipher_sched
  import aes_decipher_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_block,
  input  logic         req0_keylen,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_block,
  input  logic         req1_keylen,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_block,
`ifdef AES_SCHED_TIMEOUT_EN
  output logic         rsp_err,
`endif
  output logic         eng_next,
  output logic         eng_keylen,
  output logic [127:0] eng_block,
  input  logic [127:0] eng_new_block,
  input  logic         eng_ready
);

  if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("aes_decipher_sched: TIMEOUT_CYCLES must be within 16..255");
  end

  sched_state_t state_q, state_d;
  job_t         job_q;
  logic         in_idle;
  logic         accept;
  logic         eng_done;
  logic         wdog_expire;
  logic         gnt0, gnt1, gnt_id, gnt_any;

  aes_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0_valid),
    .req1    (req1_valid),
    .advance (in_idle),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  // Ready is also gated by rst_n: the FSM sits in IDLE during reset but must not accept.
  assign in_idle    = (state_q == ST_IDLE) && rst_n;
  assign accept     = in_idle && gnt_any;
  assign req0_ready = in_idle && gnt0;
  assign req1_ready = in_idle && gnt1;

  // Engine completion only counts while a job is actually running.
  assign eng_done = (state_q == ST_BUSY) && eng_ready;

`ifdef AES_SCHED_TIMEOUT_EN
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_q;

  // A same-cycle engine result beats the watchdog.
  assign wdog_expire = (state_q == ST_BUSY) && !eng_ready && (wdog_q == WDOG_LIMIT);

  // Watchdog clears on the way into BUSY and counts every BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (state_q == ST_LAUNCH) begin
      wdog_q <= '0;
    end else if (state_q == ST_BUSY) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  assign wdog_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and decoded FSM outputs.
  always_comb begin
    state_d   = state_q;
    eng_next  = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        eng_next = 1'b1;
        state_d  = ST_BUSY;
      end
      ST_BUSY: begin
        if (eng_done || wdog_expire) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the granted job; it only changes in IDLE so the engine inputs stay put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_q <= '0;
    end else if (accept) begin
      job_q <= '{block:  gnt_id ? req1_block  : req0_block,
                 keylen: gnt_id ? req1_keylen : req0_keylen,
                 id:     gnt_id};
    end
  end

  assign eng_block  = job_q.block;
  assign eng_keylen = job_q.keylen;
  assign rsp_id     = job_q.id;

  // Result register: loaded on completion (or zeroed on abort) and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_block <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
    end else if (eng_done) begin
      rsp_block <= eng_new_block;
`ifdef AES_SCHED_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
    end else if (wdog_expire) begin
      rsp_block <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
      rsp_err   <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_aes_decipher_sched.sv
// Bench for aes_decipher_sched with a lookup-table engine stub.
// Covers reset, arbitration, table-driven jobs, backpressure, stray eng_ready, mid-job reset, watchdog.
module tb_aes_decipher_sched;

  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] STRAY = 128'hbadc0ffee0ddf00dbadc0ffee0ddf00d;
  localparam int ENG_LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_block, req1_block;
  logic         req0_keylen, req1_keylen;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [127:0] rsp_block;
`ifdef AES_SCHED_TIMEOUT_EN
  logic         rsp_err;
`endif
  logic         eng_next, eng_keylen;
  logic [127:0] eng_block, eng_new_block;
  logic         eng_ready;

  // Engine stub outputs, plus a stray pulse source driven by the main sequence.
  logic         eng_rdy_e;
  logic [127:0] eng_blk_e;
  logic         stray;
  logic         eng_mute;

  assign eng_ready     = eng_rdy_e | stray;
  assign eng_new_block = stray ? STRAY : eng_blk_e;

  int n_cmp = 0;
  int n_err = 0;
  int next_cnt = 0;
  int hold_err = 0;
  logic kl_seen = 1'b0;
  int grant_q[$];

  always #5 clk = ~clk;

  aes_decipher_sched #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_block    (req0_block),
    .req0_keylen   (req0_keylen),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_block    (req1_block),
    .req1_keylen   (req1_keylen),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_block     (rsp_block),
`ifdef AES_SCHED_TIMEOUT_EN
    .rsp_err       (rsp_err),
`endif
    .eng_next      (eng_next),
    .eng_keylen    (eng_keylen),
    .eng_block     (eng_block),
    .eng_new_block (eng_new_block),
    .eng_ready     (eng_ready)
  );

  // Engine behaviour: FIPS-197 vectors decrypt to PT with the right key length,
  // anything else gets an easily predicted transform.
  function automatic logic [127:0] eng_model(input logic [127:0] b, input logic kl);
    if (b == CT128 && kl == 1'b0) return PT;
    if (b == CT256 && kl == 1'b1) return PT;
    return kl ? {b[63:0], b[127:64]} : ~b;
  endfunction

  // Engine stub: starts on eng_next, answers ENG_LAT cycles later, checks inputs stay stable.
  logic [127:0] e_blk;
  logic         e_kl;
  logic         e_busy;
  int           e_cnt;
  initial begin
    eng_rdy_e = 1'b0;
    eng_blk_e = '0;
    e_busy    = 1'b0;
    e_cnt     = 0;
    e_blk     = '0;
    e_kl      = 1'b0;
    forever begin
      @(posedge clk); #1;
      eng_rdy_e = 1'b0;
      if (!rst_n) begin
        e_busy = 1'b0;
      end else if (e_busy) begin
        if (eng_block !== e_blk || eng_keylen !== e_kl) hold_err++;
        e_cnt--;
        if (e_cnt == 0) begin
          e_busy = 1'b0;
          if (!eng_mute) begin
            eng_rdy_e = 1'b1;
            eng_blk_e = eng_model(e_blk, e_kl);
          end
        end
      end else if (eng_next) begin
        e_busy  = 1'b1;
        e_cnt   = ENG_LAT;
        e_blk   = eng_block;
        e_kl    = eng_keylen;
        kl_seen = eng_keylen;
      end
    end
  end

  // Grant and launch monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (req0_ready) grant_q.push_back(0);
    if (req1_ready) grant_q.push_back(1);
    if (eng_next) next_cnt++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_rsp_seen"}, 128'(rsp_valid), 128'd1);
  endtask

  typedef struct {
    logic         id;
    logic [127:0] blk;
    logic         kl;
    logic [127:0] exp;
  } vec_t;

  // Issue one job, wait for the result, check it and complete the handshake (rsp_ready=1 assumed).
  task automatic run_job(input string name, input vec_t v, output int wait_cyc);
    int n, nx0, h0;
    nx0 = next_cnt;
    h0  = hold_err;
    if (v.id) begin
      req1_valid = 1'b1; req1_block = v.blk; req1_keylen = v.kl;
    end else begin
      req0_valid = 1'b1; req0_block = v.blk; req0_keylen = v.kl;
    end
    #1;
    n = 0;
    while (!(v.id ? req1_ready : req0_ready) && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    wait_cyc = n;
    chk({name, "_accept"}, 128'(n < 50), 128'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(name);
    chk({name, "_blk"}, rsp_block, v.exp);
    chk({name, "_id"}, 128'(rsp_id), 128'(v.id));
    chk({name, "_kl"}, 128'(kl_seen), 128'(v.kl));
    chk({name, "_pulses"}, 128'(next_cnt - nx0), 128'd1);
    chk({name, "_hold"}, 128'(hold_err - h0), 128'd0);
`ifdef AES_SCHED_TIMEOUT_EN
    chk({name, "_err"}, 128'(rsp_err), 128'd0);
`endif
    tick();
  endtask

  vec_t vecs[6];

  initial begin
    int w, viol, seen, cnt;
    logic [127:0] snap, rb;

    vecs[0] = '{1'b0, CT128, 1'b0, PT};
    vecs[1] = '{1'b1, CT256, 1'b1, PT};
    vecs[2] = '{1'b0, 128'h0123456789abcdef0011223344556677, 1'b0,
                128'hfedcba9876543210ffeeddccbbaa9988};
    vecs[3] = '{1'b1, 128'hffffffffffffffff0000000000000000, 1'b1,
                128'h0000000000000000ffffffffffffffff};
    vecs[4] = '{1'b0, CT128, 1'b1, 128'hd8cdb78070b4c55a69c4e0d86a7b0430};
    vecs[5] = '{1'b1, CT256, 1'b0, 128'h715d4835ae98ba401503b66fb4b69f76};

    // Reset with both requesters already asking.
    rst_n = 1'b0;
    stray = 1'b0;
    eng_mute = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_block = {16{8'h11}}; req0_keylen = 1'b0;
    req1_valid = 1'b1; req1_block = {16{8'h22}}; req1_keylen = 1'b0;
    repeat (3) tick();
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_req0_ready", 128'(req0_ready), 128'd0);
    chk("rst_req1_ready", 128'(req1_ready), 128'd0);
    chk("rst_eng_next", 128'(eng_next), 128'd0);
    chk("rst_eng_block", eng_block, 128'd0);
    chk("rst_eng_keylen", 128'(eng_keylen), 128'd0);
    chk("rst_rsp_id", 128'(rsp_id), 128'd0);
    chk("rst_rsp_block", rsp_block, 128'd0);
`ifdef AES_SCHED_TIMEOUT_EN
    chk("rst_rsp_err", 128'(rsp_err), 128'd0);
`endif

    // Contention: both held valid, grants must alternate starting with requester 0.
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_rsp($sformatf("rr%0d", k));
      chk($sformatf("rr%0d_id", k), 128'(rsp_id), 128'(k % 2));
      chk($sformatf("rr%0d_blk", k), rsp_block, (k % 2) ? {16{8'hdd}} : {16{8'hee}});
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      tick();
    end
    tick();
    chk("rr_grant_count", 128'(grant_q.size()), 128'd4);
    for (int k = 0; k < 4 && k < grant_q.size(); k++)
      chk($sformatf("rr_grant%0d", k), 128'(grant_q[k]), 128'(k % 2));

    // Table of single jobs, including both FIPS-197 vectors and wrong-key cases.
    for (int i = 0; i < 6; i++) run_job($sformatf("vec%0d", i), vecs[i], w);

    // Stray engine pulse while idle: no response, last result kept.
    rb = rsp_block;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    chk("stray_idle_valid", 128'(rsp_valid), 128'd0);
    chk("stray_idle_blk", rsp_block, rb);

    // Backpressure: hold the result 20 cycles with a second job waiting.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_block = CT128; req0_keylen = 1'b0;
    tick();
    req0_valid = 1'b0;
    wait_rsp("bp");
    snap = rsp_block;
    chk("bp_blk", snap, PT);
    req1_valid = 1'b1; req1_block = {16{8'h33}}; req1_keylen = 1'b0;
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      stray = (c == 5);
      tick();
      if (!rsp_valid || rsp_block !== snap || rsp_id !== 1'b0 || req0_ready || req1_ready) viol++;
    end
    stray = 1'b0;
    chk("bp_stable", 128'(viol), 128'd0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_no_accept_in_hs", 128'(req1_ready), 128'd0);
    tick();
    chk("bp_valid_drop", 128'(rsp_valid), 128'd0);
    chk("bp_accept_next", 128'(req1_ready), 128'd1);
    tick();
    req1_valid = 1'b0;
    wait_rsp("bp2");
    chk("bp2_id", 128'(rsp_id), 128'd1);
    chk("bp2_blk", rsp_block, {16{8'hcc}});
    tick();

    // Reset in the middle of BUSY: job dropped, no response, then normal operation.
    req0_valid = 1'b1; req0_block = {16{8'h44}}; req0_keylen = 1'b0;
    cnt = 0;
    while (!eng_next && cnt < 20) begin tick(); cnt++; end
    chk("mid_launch_seen", 128'(eng_next), 128'd1);
    req0_valid = 1'b0;
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(rsp_valid), 128'd0);
    chk("mid_rst_eng_block", eng_block, 128'd0);
    chk("mid_rst_eng_next", 128'(eng_next), 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("mid_no_rsp", 128'(seen), 128'd0);
    run_job("mid_after", vecs[0], w);
    chk("mid_idle_accept", 128'(w), 128'd0);

`ifdef AES_SCHED_TIMEOUT_EN
    // Watchdog: engine never answers; abort after 16 BUSY cycles.
    eng_mute = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_block = {16{8'h55}}; req0_keylen = 1'b0;
    cnt = 0;
    while (!eng_next && cnt < 20) begin tick(); cnt++; end
    req0_valid = 1'b0;
    cnt = 0;
    while (!rsp_valid && cnt < 40) begin tick(); cnt++; end
    chk("to_cycles", 128'(cnt), 128'd17);
    chk("to_err", 128'(rsp_err), 128'd1);
    chk("to_blk", rsp_block, 128'd0);
    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk("to_stray_blk", rsp_block, 128'd0);
    chk("to_stray_err", 128'(rsp_err), 128'd1);
    rsp_ready = 1'b1;
    tick();
    eng_mute = 1'b0;
    run_job("to_after", vecs[1], w);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_decipher_sched.md
AES_DECIPHER_SCHED -- requirements
Module: aes_decipher_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32: BUSY-state watchdog limit in clk cycles; legal range 16..255.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0/1 has a job.
REQ-005 req0_ready / req1_ready  output  1 each  job accepted this cycle.
REQ-006 req0_block / req1_block  input  128 each  ciphertext block.
REQ-007 req0_keylen / req1_keylen  input  1 each  0 = AES-128, 1 = AES-256.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  1  originating requester.
REQ-011 rsp_block  output  128  plaintext result.
REQ-012 rsp_err  output  1  watchdog abort; present only with AES_SCHED_TIMEOUT_EN.
REQ-013 eng_next  output  1  one-cycle start pulse to the decipher engine.
REQ-014 eng_keylen  output  1  key length to engine.
REQ-015 eng_block  output  128  block to engine.
REQ-016 eng_new_block  input  128  engine result.
REQ-017 eng_ready  input  1  engine one-cycle done pulse; eng_new_block valid in that cycle.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, BUSY, RESP.
REQ-019 IDLE: when any reqN_valid=1, grant exactly one requester, assert its reqN_ready combinationally in that cycle, capture block/keylen/id, go to LAUNCH.
REQ-020 Arbitration: round-robin; when both valid, grant the requester not granted last; single valid is granted regardless.
REQ-021 reqN_ready SHALL be 0 in every state except IDLE.
REQ-022 LAUNCH: eng_next=1 for exactly one cycle, then BUSY; eng_next=0 in all other states.
REQ-023 eng_block and eng_keylen SHALL hold the captured job unchanged from LAUNCH until leaving BUSY.
REQ-024 BUSY: on eng_ready=1, capture eng_new_block into rsp_block, go to RESP.
REQ-025 eng_ready outside BUSY SHALL be ignored.
REQ-026 RESP: rsp_valid=1, rsp_block/rsp_id stable; on rsp_ready=1, go to IDLE; rsp_valid drops the next cycle.
REQ-027 New request acceptance SHALL NOT occur in the cycle rsp handshake completes; earliest acceptance is the following IDLE cycle.
REQ-028 rsp_block SHALL hold its last value after RESP exits.

Reset
REQ-029 On rst_n=0: state IDLE, reqN_ready=0, rsp_valid=0, rsp_id=0, rsp_block=0, rsp_err=0, eng_next=0, eng_block=0, eng_keylen=0, watchdog=0, last-grant=1, so requester 0 wins the first contention.
REQ-030 Reset mid-job SHALL discard the job with no response; outputs take reset values asynchronously.

Configuration
REQ-031 Macro AES_SCHED_TIMEOUT_EN defined: 8-bit watchdog clears on BUSY entry and increments each BUSY cycle. At TIMEOUT_CYCLES-1 without eng_ready, go to RESP with rsp_err=1 and rsp_block=0. rsp_err=0 on normal completion. Same-cycle eng_ready wins over timeout.
REQ-032 Macro undefined: no watchdog or rsp_err port; BUSY waits indefinitely.

Structure
REQ-033 Shared AES package: FSM state encoding, AES_128_BIT_KEY/AES_256_BIT_KEY constants, round counts 10/14.
REQ-034 One sub-module, aes_rr_arb2 (2-way round-robin arbiter with last-grant register); the rest is flat.

Verification
REQ-035 Single job: req0 ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, keylen=0, with engine and key 000102..0f. Required: rsp_block 00112233445566778899aabbccddeeff, rsp_id=0, one eng_next pulse.
REQ-036 Contention: both valid from reset. Required: req0 served, then req1; keeping both valid alternates grants 0,1,0,1.
REQ-037 Backpressure: rsp_ready=0 for 20 cycles. Required: rsp_valid/rsp_block/rsp_id stable, reqN_ready=0 throughout, next job accepted one cycle after the handshake.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=16): stub engine never asserts eng_ready. Required: RESP with rsp_err=1, rsp_block=0 after 16 BUSY cycles; a stray eng_ready later is ignored.
REQ-039 Reset mid-BUSY: drop rst_n for 2 cycles. Required: rsp_valid=0, state IDLE, no response for the discarded job, next job completes normally.
REQ-040 AES-256 job: keylen=1. Required: eng_keylen=1 held from LAUNCH through BUSY, result matches FIPS-197 AES-256 vector.
